gzip_inv_iter: RTL
==================

# gzip_inv_iter

Multi-cycle inverse of the generalized zip/unzip (gzip) permutation on 32-bit words. Given a result word and the 5-bit gzip control used to produce it, the block recovers the original operand by applying the enabled butterfly stages in reverse order, one stage per clock. It sits beside the single-cycle gzip unit in the bitmanip execution path and exchanges operands over valid/ready handshakes.

## Interface
- `SKIP_IDLE_STAGES`, default 0: 0 means every operation takes all 4 stage cycles (disabled stages pass through); 1 means disabled stages take no cycle.
- `clock`  in  1  sole clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request.
- `in_data`  in  32  gzip result word to invert.
- `in_ctrl`  in  5  forward gzip control: bit0 is the forward stage order (1 = ascending 1,2,4,8; 0 = descending 8,4,2,1). Bits 1..4 enable the shamt 1/2/4/8 stages.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  32  recovered operand, so that gzip(out_data, in_ctrl) == in_data.

## Operation
- Stage k swaps the bits under maskL with the bits under maskR, over a distance of shamt: `y = (x & ~(L|R)) | ((x<<s)&L) | ((x>>s)&R)`.
  - s=1: L=0x44444444, R=0x22222222
  - s=2: L=0x30303030, R=0x0c0c0c0c
  - s=4: L=0x0f000f00, R=0x00f000f0
  - s=8: L=0x00ff0000, R=0x0000ff00
- Each stage is self-inverse. The inverse therefore applies the enabled stages in reverse of the forward order:
  - ctrl[0]=1: stages run 8,4,2,1.
  - ctrl[0]=0: stages run 1,2,4,8.
- FSM states:
  - IDLE → RUN on accept. The accept edge latches in_data into the work register, latches ctrl, and sets step=0.
  - RUN: each edge applies stage order[step] if it is enabled (otherwise passes through) and increments step. The edge that processes the last step moves to DONE.
  - DONE: out_valid=1 and out_data holds the work register. On out_valid&&out_ready, go to IDLE, or load a new request directly if one is accepted on the same edge.
- With SKIP_IDLE_STAGES=1:
  - RUN visits only the enabled stages, in order.
  - If ctrl[4:1]==0, the accept edge goes straight to DONE with out_data=in_data.
- ctrl[0] is ignored when only one stage, or no stage, is enabled.

## Timing
- Reset values: state=IDLE, out_valid=0, out_data=0, in_ready=0 while resetn is low. in_ready goes to 1 in the first cycle after release.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is combinational, has no in_valid dependency, and is low throughout RUN.
- Accept on the rising edge where in_valid&&in_ready.
- out_valid rises k edges after the accept edge:
  - k=4 when SKIP_IDLE_STAGES=0.
  - k=max(popcount(ctrl[4:1]),0) when SKIP_IDLE_STAGES=1. k=0 means out_valid is seen in the cycle right after accept.
- Back-to-back throughput: one result per k+1 cycles. Completion and the next accept can occur on the same edge with no bubble.
- out_data and out_valid stay stable while out_valid && !out_ready. Changes in in_data/in_ctrl after acceptance have no effect.
- Asserting resetn mid-RUN or mid-DONE aborts the operation immediately. The result is lost and no out_valid pulse is produced.

## Structure
- Package `gzip_pkg` holds the stage mask/shamt constants, a `gzip_stage` function, and the state enum. The forward gzip unit shares the package.
- One sub-module, `gzip_stage_mux`: a combinational block that selects the stage by index and applies it. It is instantiated once and driven by step/order logic.
- Stage-order selection and the FSM stay in gzip_inv_iter.

## Test plan
- in_data=0x55555555, ctrl=0x1E → out_data=0x0000FFFF, 4 cycles after accept (SKIP=0).
- in_data=0x0000FFFF, ctrl=0x1F → out_data=0x55555555.
- in_data=0x12563478, ctrl=0x10, SKIP=1 → out_data=0x12345678 after 1 cycle. ctrl=0x01 with SKIP=1 → identity, out_valid the cycle after accept.
- Hold out_ready=0 for 10 cycles → out_valid/out_data stable and in_ready=0. Release with in_valid high → the next accept happens on the same edge as completion.
- Pulse resetn low mid-RUN → out_valid=0 and out_data=0 immediately, no result emitted, in_ready=1 the cycle after release.
- Random data/ctrl for 10k operations, checked against a reference gzip round-trip (gzip(out_data,ctrl)==in_data), with randomized valid/ready stalls.

Source files
------------

// File: rtl/gzip_pkg.sv
// rtl/gzip_pkg.sv - gzip butterfly stage constants, stage function and FSM state type
package gzip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } gzip_state_e;

  localparam int unsigned GZIP_NSTAGES = 4;

  // Stage index 0..3 maps to shamt 1, 2, 4, 8.
  function automatic logic [31:0] gzip_mask_l(input logic [1:0] idx);
    case (idx)
      2'd0:    return 32'h4444_4444;
      2'd1:    return 32'h3030_3030;
      2'd2:    return 32'h0f00_0f00;
      default: return 32'h00ff_0000;
    endcase
  endfunction

  function automatic logic [31:0] gzip_mask_r(input logic [1:0] idx);
    case (idx)
      2'd0:    return 32'h2222_2222;
      2'd1:    return 32'h0c0c_0c0c;
      2'd2:    return 32'h00f0_00f0;
      default: return 32'h0000_ff00;
    endcase
  endfunction

  function automatic logic [4:0] gzip_shamt(input logic [1:0] idx);
    return 5'd1 << idx;
  endfunction

  // One butterfly stage; it is its own inverse.
  function automatic logic [31:0] gzip_stage(input logic [31:0] x, input logic [1:0] idx);
    logic [31:0] ml;
    logic [31:0] mr;
    logic [4:0]  sh;
    ml = gzip_mask_l(idx);
    mr = gzip_mask_r(idx);
    sh = gzip_shamt(idx);
    return (x & ~(ml | mr)) | ((x << sh) & ml) | ((x >> sh) & mr);
  endfunction

endpackage

// File: rtl/gzip_stage_mux.sv
// rtl/gzip_stage_mux.sv - applies one selected gzip stage, or passes data through
module gzip_stage_mux
  import gzip_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  stage,
  input  logic        enable,
  output logic [31:0] result
);

  assign result = enable ? gzip_stage(data, stage) : data;

endmodule

// File: rtl/gzip_inv_iter.sv
// rtl/gzip_inv_iter.sv - iterative inverse gzip, one butterfly stage per clock
module gzip_inv_iter
  import gzip_pkg::*;
#(
  parameter bit SKIP_IDLE_STAGES = 1'b0
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_ctrl,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  gzip_state_e state, state_nx;
  logic [31:0] work, work_nx;
  logic [4:0]  ctrl_q, ctrl_nx;
  logic [1:0]  step, step_nx;
  logic [3:0]  pend, pend_nx;

  logic [3:0]  in_en_ord;
  logic [3:0]  en_q;
  logic [3:0]  pend_clr;
  logic [1:0]  low_pos;
  logic [1:0]  pos;
  logic [1:0]  stage_idx;
  logic        stage_en;
  logic        last_step;
  logic        accept;
  logic [31:0] stage_out;

  // Enables rearranged into inverse-execution order (position 0 runs first).
  function automatic logic [3:0] order_enables(input logic [4:0] ctrl);
    logic [3:0] en;
    logic [3:0] ord;
    en = ctrl[4:1];
    for (int p = 0; p < 4; p++) begin
      ord[p] = ctrl[0] ? en[3-p] : en[p];
    end
    return ord;
  endfunction

  assign in_en_ord = order_enables(in_ctrl);
  assign en_q      = ctrl_q[4:1];

  always_comb begin
    low_pos = 2'd0;
    for (int p = 3; p >= 0; p--) begin
      if (pend[p]) low_pos = 2'(p);
    end
  end

  assign pos       = SKIP_IDLE_STAGES ? low_pos : step;
  // Forward ascending means the inverse walks 8,4,2,1.
  assign stage_idx = ctrl_q[0] ? ~pos : pos;
  assign stage_en  = en_q[stage_idx];
  assign pend_clr  = pend & ~(4'b0001 << pos);
  assign last_step = SKIP_IDLE_STAGES ? (pend_clr == 4'd0) : (step == 2'd3);

  gzip_stage_mux u_stage_mux (
    .data   (work),
    .stage  (stage_idx),
    .enable (stage_en),
    .result (stage_out)
  );

  assign in_ready  = resetn && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign out_data  = work;

  always_comb begin
    state_nx = state;
    work_nx  = work;
    ctrl_nx  = ctrl_q;
    step_nx  = step;
    pend_nx  = pend;
    case (state)
      ST_RUN: begin
        work_nx = stage_out;
        step_nx = step + 2'd1;
        pend_nx = pend_clr;
        if (last_step) state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_nx = ST_IDLE;
      end
      default: ;
    endcase
    // A new request may land on the same edge that retires the previous result.
    if (accept) begin
      work_nx  = in_data;
      ctrl_nx  = in_ctrl;
      step_nx  = 2'd0;
      pend_nx  = in_en_ord;
      state_nx = (SKIP_IDLE_STAGES && (in_en_ord == 4'd0)) ? ST_DONE : ST_RUN;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      work   <= 32'd0;
      ctrl_q <= 5'd0;
      step   <= 2'd0;
      pend   <= 4'd0;
    end else begin
      state  <= state_nx;
      work   <= work_nx;
      ctrl_q <= ctrl_nx;
      step   <= step_nx;
      pend   <= pend_nx;
    end
  end

endmodule
